// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings for the MEM stage (mem_op, FSM states, rf_sel, MEM/WB slot)
package mem_stage_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_SEL_PC4 = 2'd2;
  localparam logic [1:0] RF_SEL_IMM = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic [1:0]  rf_sel;
    logic [4:0]  wr;
    logic [31:0] pc4;
    logic [31:0] alu_c;
    logic [31:0] imm;
    logic [31:0] rdata;
  } wb_slot_t;

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - load lane extraction and sign/zero extension
// Lane selection is active only when SUBWORD_ACCESS_EN is defined; otherwise the raw word passes through.
module mem_load_ext (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mem_op,
  output logic [31:0] data
);
  import mem_stage_pkg::*;

`ifdef SUBWORD_ACCESS_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    // halfword lane ignores offset[0]; misaligned halves read the containing half
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (mem_op)
      MEM_OP_B:  data = {{24{lane_b[7]}}, lane_b};
      MEM_OP_BU: data = {24'h0, lane_b};
      MEM_OP_H:  data = {{16{lane_h[15]}}, lane_h};
      MEM_OP_HU: data = {16'h0, lane_h};
      default:   data = rdata;
    endcase
  end
`else
  logic unused_sel;
  assign unused_sel = ^{offset, mem_op};
  assign data       = rdata;
`endif

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-memory handshake FSM and MEM/WB slot
// Sub-word stores/loads are enabled by defining SUBWORD_ACCESS_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        valid_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] alu_c_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  rf_sel_i,
  input  logic        rf_we_i,
  input  logic [4:0]  wr_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] imm_i,
  output logic        dram_req_o,
  output logic        dram_we_o,
  output logic [31:0] dram_addr_o,
  output logic [31:0] dram_wdata_o,
  output logic [3:0]  dram_wstrb_o,
  input  logic        dram_ack_i,
  input  logic [31:0] dram_rdata_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic        wb_rf_we_o,
  output logic [1:0]  wb_rf_sel_o,
  output logic [4:0]  wb_wr_o,
  output logic [31:0] wb_pc4_o,
  output logic [31:0] wb_alu_c_o,
  output logic [31:0] wb_imm_o,
  output logic [31:0] wb_dram_rdata_o
);

  mem_state_e state, state_nxt;
  wb_slot_t   wb_q, wb_nxt;
  logic       start;

  // instruction captured when the access starts; drives the bus and the DONE writeback
  logic        hold_we, hold_ld, hold_rf_we;
  logic [2:0]  hold_op;
  logic [1:0]  hold_rf_sel;
  logic [4:0]  hold_wr;
  logic [31:0] hold_alu, hold_wdata, hold_pc4, hold_imm;
  logic [31:0] load_data, ext_data;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  assign start = valid_i && (mem_re_i || mem_we_i);

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    dram_req_o = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stall_o   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_o    = 1'b1;
        dram_req_o = 1'b1;
        if (dram_ack_i) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = hold_wdata;
`ifdef SUBWORD_ACCESS_EN
    case (hold_op)
      MEM_OP_B: begin
        st_strb  = 4'b0001 << hold_alu[1:0];
        st_wdata = {4{hold_wdata[7:0]}};
      end
      MEM_OP_H: begin
        st_strb  = hold_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{hold_wdata[15:0]}};
      end
      default: ;
    endcase
`endif
  end

  assign dram_addr_o  = {hold_alu[31:2], 2'b00};
  assign dram_wdata_o = st_wdata;
  assign dram_we_o    = dram_req_o && hold_we;
  assign dram_wstrb_o = dram_we_o ? st_strb : 4'b0000;

  mem_load_ext u_load_ext (
    .rdata  (dram_rdata_i),
    .offset (hold_alu[1:0]),
    .mem_op (hold_op),
    .data   (ext_data)
  );

  always_comb begin
    wb_nxt = '0;
    if (state == ST_DONE) begin
      wb_nxt.valid  = 1'b1;
      wb_nxt.rf_we  = hold_rf_we;
      wb_nxt.rf_sel = hold_rf_sel;
      wb_nxt.wr     = hold_wr;
      wb_nxt.pc4    = hold_pc4;
      wb_nxt.alu_c  = hold_alu;
      wb_nxt.imm    = hold_imm;
      wb_nxt.rdata  = load_data;
    end else if (state == ST_IDLE && valid_i && !start) begin
      wb_nxt.valid  = 1'b1;
      wb_nxt.rf_we  = rf_we_i;
      wb_nxt.rf_sel = rf_sel_i;
      wb_nxt.wr     = wr_i;
      wb_nxt.pc4    = pc4_i;
      wb_nxt.alu_c  = alu_c_i;
      wb_nxt.imm    = imm_i;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state       <= ST_IDLE;
      wb_q        <= '0;
      load_data   <= '0;
      hold_we     <= 1'b0;
      hold_ld     <= 1'b0;
      hold_rf_we  <= 1'b0;
      hold_op     <= '0;
      hold_rf_sel <= '0;
      hold_wr     <= '0;
      hold_alu    <= '0;
      hold_wdata  <= '0;
      hold_pc4    <= '0;
      hold_imm    <= '0;
    end else begin
      state <= state_nxt;
      wb_q  <= wb_nxt;
      if (state == ST_IDLE && start) begin
        hold_we     <= mem_we_i;
        hold_ld     <= mem_re_i && !mem_we_i;
        hold_rf_we  <= rf_we_i;
        hold_op     <= mem_op_i;
        hold_rf_sel <= rf_sel_i;
        hold_wr     <= wr_i;
        hold_alu    <= alu_c_i;
        hold_wdata  <= wdata_i;
        hold_pc4    <= pc4_i;
        hold_imm    <= imm_i;
      end
      if (state == ST_REQ && dram_ack_i) load_data <= hold_ld ? ext_data : 32'h0;
    end
  end

  assign wb_valid_o      = wb_q.valid;
  assign wb_rf_we_o      = wb_q.rf_we;
  assign wb_rf_sel_o     = wb_q.rf_sel;
  assign wb_wr_o         = wb_q.wr;
  assign wb_pc4_o        = wb_q.pc4;
  assign wb_alu_c_o      = wb_q.alu_c;
  assign wb_imm_o        = wb_q.imm;
  assign wb_dram_rdata_o = wb_q.rdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage (expectations follow SUBWORD_ACCESS_EN)
module tb_mem_stage;

`ifdef SUBWORD_ACCESS_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        valid_i, mem_re_i, mem_we_i, rf_we_i, dram_ack_i;
  logic [2:0]  mem_op_i;
  logic [31:0] alu_c_i, wdata_i, pc4_i, imm_i, dram_rdata_i;
  logic [1:0]  rf_sel_i;
  logic [4:0]  wr_i;
  logic        dram_req_o, dram_we_o, stall_o, wb_valid_o, wb_rf_we_o;
  logic [31:0] dram_addr_o, dram_wdata_o, wb_pc4_o, wb_alu_c_o, wb_imm_o, wb_dram_rdata_o;
  logic [3:0]  dram_wstrb_o;
  logic [1:0]  wb_rf_sel_o;
  logic [4:0]  wb_wr_o;

  typedef struct {
    logic        rf_we;
    logic [1:0]  rf_sel;
    logic [4:0]  wr;
    logic [31:0] pc4;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] rd;
  } wb_exp_t;

  wb_exp_t sb[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  logic    prev_stall = 1'b0;

  always #5 cpu_clk = ~cpu_clk;

  mem_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .valid_i(valid_i), .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i), .mem_op_i(mem_op_i), .alu_c_i(alu_c_i), .wdata_i(wdata_i),
    .rf_sel_i(rf_sel_i), .rf_we_i(rf_we_i), .wr_i(wr_i), .pc4_i(pc4_i), .imm_i(imm_i),
    .dram_req_o(dram_req_o), .dram_we_o(dram_we_o), .dram_addr_o(dram_addr_o),
    .dram_wdata_o(dram_wdata_o), .dram_wstrb_o(dram_wstrb_o), .dram_ack_i(dram_ack_i),
    .dram_rdata_i(dram_rdata_i), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_rf_we_o(wb_rf_we_o), .wb_rf_sel_o(wb_rf_sel_o), .wb_wr_o(wb_wr_o),
    .wb_pc4_o(wb_pc4_o), .wb_alu_c_o(wb_alu_c_o), .wb_imm_o(wb_imm_o),
    .wb_dram_rdata_o(wb_dram_rdata_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MEM/WB monitor: pop an expected slot per valid writeback; stalled cycles must produce bubbles
  always @(negedge cpu_clk) begin
    if (prev_stall === 1'b1) check("bubble_after_stall", {31'h0, wb_valid_o}, 32'h0);
    if (wb_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'h1, 32'h0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_rf_we",  {31'h0, wb_rf_we_o}, {31'h0, e.rf_we});
        check("wb_rf_sel", {30'h0, wb_rf_sel_o}, {30'h0, e.rf_sel});
        check("wb_wr",     {27'h0, wb_wr_o}, {27'h0, e.wr});
        check("wb_pc4",    wb_pc4_o, e.pc4);
        check("wb_alu_c",  wb_alu_c_o, e.alu);
        check("wb_imm",    wb_imm_o, e.imm);
        check("wb_rdata",  wb_dram_rdata_o, e.rd);
      end
    end
    prev_stall = stall_o;
  end

  // called at posedge+1; returns at posedge+1 after the instruction leaves EX/MEM
  task automatic do_instr(input string tag, input logic v, input logic re, input logic we,
                          input logic [2:0] op, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ack_dly, input logic [31:0] exp_rd,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    int      stalls = 0;
    int      reqs   = 0;
    bit      done   = 0;
    int      exp_stall;
    wb_exp_t e;
    valid_i      = v;
    mem_re_i     = re;
    mem_we_i     = we;
    mem_op_i     = op;
    alu_c_i      = alu;
    wdata_i      = wd;
    dram_rdata_i = rdata;
    rf_we_i      = !we;
    rf_sel_i     = (re && !we) ? 2'd1 : 2'd0;
    wr_i         = alu[6:2];
    pc4_i        = 32'h1000 + alu;
    imm_i        = ~alu;
    exp_stall    = (v && (re || we)) ? ack_dly + 1 : 0;
    if (v) begin
      e.rf_we = !we; e.rf_sel = rf_sel_i; e.wr = alu[6:2];
      e.pc4 = 32'h1000 + alu; e.alu = alu; e.imm = ~alu; e.rd = exp_rd;
      sb.push_back(e);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge cpu_clk);
      if (stall_o) stalls++;
      if (dram_req_o) begin
        reqs++;
        check({tag, "_addr"}, dram_addr_o, {alu[31:2], 2'b00});
        check({tag, "_we"}, {31'h0, dram_we_o}, {31'h0, we});
        check({tag, "_strb"}, {28'h0, dram_wstrb_o}, {28'h0, exp_strb});
        if (we) check({tag, "_wdata"}, dram_wdata_o, exp_wd);
        if (reqs == ack_dly) dram_ack_i = 1'b1;
      end
      if (!stall_o) begin
        done = 1;
        break;
      end
      @(posedge cpu_clk);
      #1;
      dram_ack_i = 1'b0;
    end
    if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
    check({tag, "_stall_cycles"}, stalls, exp_stall);
    if (exp_stall == 0) check({tag, "_no_req"}, reqs, 0);
    @(posedge cpu_clk);
    #1;
    dram_ack_i = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1; valid_i = 0; mem_re_i = 0; mem_we_i = 0; mem_op_i = 0;
    alu_c_i = 0; wdata_i = 0; rf_sel_i = 0; rf_we_i = 0; wr_i = 0; pc4_i = 0; imm_i = 0;
    dram_ack_i = 0; dram_rdata_i = 0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check("rst_wb_valid", {31'h0, wb_valid_o}, 32'h0);
    check("rst_dram_req", {31'h0, dram_req_o}, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    check("rst_wb_rdata", wb_dram_rdata_o, 32'h0);
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;

    do_instr("alu", 1, 0, 0, 3'b000, 32'h10, 0, 0, 0, 0, 0, 0);
    check("alu_lat_valid", {31'h0, wb_valid_o}, 32'h1);
    check("alu_lat_c", wb_alu_c_o, 32'h10);
    do_instr("lw", 1, 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 4'b0000, 0);
    do_instr("lb", 1, 1, 0, 3'b000, 32'h103, 0, 32'h80112233, 1,
             SUB ? 32'hFFFFFF80 : 32'h80112233, 4'b0000, 0);
    do_instr("lbu", 1, 1, 0, 3'b100, 32'h103, 0, 32'h80112233, 2,
             SUB ? 32'h00000080 : 32'h80112233, 4'b0000, 0);
    do_instr("lh", 1, 1, 0, 3'b001, 32'h103, 0, 32'h80112233, 1,
             SUB ? 32'hFFFF8011 : 32'h80112233, 4'b0000, 0);
    do_instr("lhu", 1, 1, 0, 3'b101, 32'h100, 0, 32'h80112233, 1,
             SUB ? 32'h00002233 : 32'h80112233, 4'b0000, 0);
    do_instr("sh", 1, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'h55555555, 2, 0,
             SUB ? 4'b1100 : 4'b1111, SUB ? 32'hABCDABCD : 32'h0000ABCD);
    do_instr("sb", 1, 0, 1, 3'b000, 32'h101, 32'h12345678, 32'h55555555, 1, 0,
             SUB ? 4'b0010 : 4'b1111, SUB ? 32'h78787878 : 32'h12345678);
    do_instr("sw_rewe", 1, 1, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h11111111, 2, 0,
             4'b1111, 32'hCAFEF00D);
    do_instr("novalid", 0, 1, 0, 3'b010, 32'h300, 0, 32'h99999999, 1, 0, 0, 0);
    do_instr("b2b_lw", 1, 1, 0, 3'b010, 32'h300, 0, 32'h01234567, 1, 32'h01234567, 4'b0000, 0);
    do_instr("b2b_sw", 1, 0, 1, 3'b010, 32'h304, 32'h76543210, 0, 1, 0, 4'b1111, 32'h76543210);
    do_instr("alu2", 1, 0, 0, 3'b000, 32'h44, 0, 0, 0, 0, 0, 0);

    // reset while a load is waiting for its ack, then a stray ack
    valid_i = 1; mem_re_i = 1; mem_we_i = 0; mem_op_i = 3'b010; alu_c_i = 32'h400;
    dram_rdata_i = 32'hBADBAD00;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check("rstreq_req_seen", {31'h0, dram_req_o}, 32'h1);
    cpu_rst = 1'b1;
    valid_i = 0; mem_re_i = 0;
    @(posedge cpu_clk);
    #1;
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check("rstreq_dram_req", {31'h0, dram_req_o}, 32'h0);
    check("rstreq_stall", {31'h0, stall_o}, 32'h0);
    check("rstreq_wb_valid", {31'h0, wb_valid_o}, 32'h0);
    check("rstreq_wb_rf_we", {31'h0, wb_rf_we_o}, 32'h0);
    check("rstreq_wb_alu_c", wb_alu_c_o, 32'h0);
    check("rstreq_wb_pc4", wb_pc4_o, 32'h0);
    check("rstreq_wb_imm", wb_imm_o, 32'h0);
    check("rstreq_wb_rdata", wb_dram_rdata_o, 32'h0);
    dram_ack_i = 1'b1;
    @(posedge cpu_clk);
    #1;
    dram_ack_i = 1'b0;
    repeat (3) begin
      @(negedge cpu_clk);
      check("stray_ack_wb_valid", {31'h0, wb_valid_o}, 32'h0);
      check("stray_ack_req", {31'h0, dram_req_o}, 32'h0);
    end

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
